// File: rtl/pp_adder_pkg.sv
// Shared constants and state encoding for the partial-product accumulation stage.
package pp_adder_pkg;

  localparam int unsigned DATA_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [DATA_W-1:0] SAT_ALL_ONES = '1;

endpackage

// File: rtl/pp_lf_adder.sv
// 12-bit Ladner-Fischer parallel-prefix adder (minimum-depth prefix tree).
module pp_lf_adder
  import pp_adder_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              cin_i,
  output logic [DATA_W-1:0] sum_o,
  output logic              cout_o
);

  localparam int unsigned LVLS = $clog2(DATA_W);

  logic [DATA_W-1:0] p0;
  logic [DATA_W-1:0] g;
  logic [DATA_W-1:0] p;
  logic [DATA_W-1:0] gn;
  logic [DATA_W-1:0] pn;
  logic [DATA_W:0]   c;

  // Each level merges the upper half of every 2^(l+1) group with the top of its lower half.
  always_comb begin
    p0 = a_i ^ b_i;
    g  = a_i & b_i;
    p  = p0;
    gn = g;
    pn = p;
    c  = '0;
    for (int l = 0; l < int'(LVLS); l++) begin
      gn = g;
      pn = p;
      for (int i = 0; i < int'(DATA_W); i++) begin
        if (((i >> l) & 1) == 1) begin
          gn[i] = g[i] | (p[i] & g[((i >> l) << l) - 1]);
          pn[i] = p[i] & p[((i >> l) << l) - 1];
        end
      end
      g = gn;
      p = pn;
    end
    c[0] = cin_i;
    for (int i = 0; i < int'(DATA_W); i++) begin
      c[i+1] = g[i] | (p[i] & cin_i);
    end
  end

  assign sum_o  = p0 ^ c[DATA_W-1:0];
  assign cout_o = c[DATA_W];

endmodule

// File: rtl/pp_accum_stage.sv
// Packet accumulator: sums 12-bit beats per packet and counts carry-outs.
// Define PP_ACCUM_SATURATE_EN to clamp the running sum to all-ones on carry.
module pp_accum_stage
  import pp_adder_pkg::*;
#(
  parameter int unsigned OVF_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OVF_W-1:0]  out_ovf
);

  localparam logic [OVF_W-1:0] OVF_MAX = '1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [OVF_W-1:0]  ovf_q, ovf_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [OVF_W-1:0]  out_ovf_q, out_ovf_d;
  logic              ready_q, ready_d;

  logic [DATA_W-1:0] sum;
  logic              cout;
  logic [DATA_W-1:0] beat_sum;
  logic [OVF_W-1:0]  ovf_inc;
  logic              accept;

  pp_lf_adder u_adder (
    .a_i    (acc_q),
    .b_i    (in_data),
    .cin_i  (1'b0),
    .sum_o  (sum),
    .cout_o (cout)
  );

`ifdef PP_ACCUM_SATURATE_EN
  // Once clamped, any further non-zero beat carries again, so the clamp holds for the packet.
  assign beat_sum = cout ? SAT_ALL_ONES : sum;
`else
  assign beat_sum = sum;
`endif

  assign ovf_inc = (ovf_q == OVF_MAX) ? OVF_MAX : ovf_q + OVF_W'(cout);
  assign accept  = in_valid & ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= '0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      ready_q     <= ready_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          if (in_last) begin
            out_data_d  = beat_sum;
            out_ovf_d   = ovf_inc;
            out_valid_d = 1'b1;
            acc_d       = '0;
            ovf_d       = '0;
            state_d     = HOLD;
          end else begin
            acc_d   = beat_sum;
            ovf_d   = ovf_inc;
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered ready keeps in_ready free of any combinational path from out_ready.
    ready_d = (state_d != HOLD);
  end

  assign in_ready  = ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_pp_accum_stage.sv
// Self-checking bench for pp_accum_stage: packet-level arithmetic model plus directed vectors.
module tb_pp_accum_stage;

  localparam int OVF_W   = 4;
  localparam int OVF_MAX = (1 << OVF_W) - 1;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [11:0]       in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [11:0]       out_data;
  logic [OVF_W-1:0]  out_ovf;

  int vec;
  int errs;

  int m_acc;
  int m_cnt;
  bit m_valid;
  int m_exp_data;
  int m_exp_ovf;

  pp_accum_stage #(.OVF_W(OVF_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    vec++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Packet-level model: integer sums, carry whenever the running total reaches 4096.
  always @(posedge clk) begin
    int tot;
    int s;
    bit c;
    if (rst) begin
      m_acc   = 0;
      m_cnt   = 0;
      m_valid = 0;
    end else if (m_valid) begin
      if (out_ready) m_valid = 0;
    end else if (in_valid) begin
      tot = m_acc + int'(in_data);
      c   = (tot >= 4096);
      s   = tot % 4096;
`ifdef PP_ACCUM_SATURATE_EN
      if (c) s = 4095;
`endif
      m_cnt = (m_cnt + int'(c) > OVF_MAX) ? OVF_MAX : m_cnt + int'(c);
      if (in_last) begin
        m_exp_data = s;
        m_exp_ovf  = m_cnt;
        m_valid    = 1;
        m_acc      = 0;
        m_cnt      = 0;
      end else begin
        m_acc = s;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", int'(out_valid), int'(m_valid));
      chk("in_ready", int'(in_ready), int'(!m_valid));
      if (m_valid) begin
        chk("out_data", int'(out_data), m_exp_data);
        chk("out_ovf", int'(out_ovf), m_exp_ovf);
      end
    end
  end

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 12'($urandom);
      in_last  = 1'($urandom);
    end
  endtask

  task automatic beat(input logic [11:0] d, input logic last);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic expect_res(input string nm, input int d, input int o);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 12'($urandom);
    chk({nm, "_valid"}, int'(out_valid), 1);
    chk({nm, "_data"}, int'(out_data), d);
    chk({nm, "_ovf"}, int'(out_ovf), o);
    chk({nm, "_model"}, m_exp_data, d);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec = 0;
    errs = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_ovf", int'(out_ovf), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // Three-beat packet, no carries.
    beat(12'h100, 1'b0);
    beat(12'h200, 1'b0);
    beat(12'h300, 1'b1);
    expect_res("sum3", 'h600, 0);
    idle(2);

    // Carry-out on the final beat.
    beat(12'hFFF, 1'b0);
    beat(12'h002, 1'b1);
`ifdef PP_ACCUM_SATURATE_EN
    expect_res("carry", 'hFFF, 1);
`else
    expect_res("carry", 'h001, 1);
`endif
    idle(2);

    // Single beat held under back-pressure; a beat offered on the retire edge must wait.
    out_ready = 1'b0;
    beat(12'hABC, 1'b1);
    expect_res("single", 'hABC, 0);
    repeat (5) @(negedge clk);
    chk("hold_in_ready", int'(in_ready), 0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 12'h007;
    in_last   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("retire_valid", int'(out_valid), 0);
    chk("retire_in_ready", int'(in_ready), 1);
    @(posedge clk);
    expect_res("after_retire", 'h007, 0);
    idle(2);

    // Twenty full-scale beats saturate the carry counter.
    for (int k = 0; k < 20; k++) beat(12'hFFF, 1'(k == 19));
`ifdef PP_ACCUM_SATURATE_EN
    expect_res("ovf_sat", 'hFFF, 15);
`else
    expect_res("ovf_sat", 'hFEC, 15);
`endif
    idle(2);

    // Reset mid-packet discards the partial sum.
    beat(12'h010, 1'b0);
    beat(12'h010, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_valid", int'(out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    beat(12'h005, 1'b1);
    expect_res("post_rst", 'h005, 0);
    idle(2);

    // Reset while holding a result drops it.
    out_ready = 1'b0;
    beat(12'h123, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("holdrst_valid", int'(out_valid), 0);
    chk("holdrst_data", int'(out_data), 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    idle(2);
    beat(12'h0F0, 1'b0);
    beat(12'h00F, 1'b1);
    expect_res("two_beat", 'h0FF, 0);
    idle(3);

    // Mixed packets checked by the model, with idle gaps carrying junk data.
    for (int p = 0; p < 6; p++) begin
      int len;
      len = int'($urandom_range(1, 5));
      for (int k = 0; k < len; k++) begin
        beat(12'($urandom), 1'(k == len - 1));
        if ($urandom_range(0, 1) == 1) idle(1);
      end
      out_ready = 1'($urandom_range(0, 1));
      idle(2);
      out_ready = 1'b1;
      idle(1);
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/pp_accum_stage.md
PP_ACCUM_STAGE -- requirements
Module: pp_accum_stage

Interface
REQ-001 Parameter OVF_W, default 4, width of the per-packet carry-out counter.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  operand beat valid.
REQ-005 in_ready  output  1  stage can accept a beat this cycle.
REQ-006 in_data  input  12  unsigned operand.
REQ-007 in_last  input  1  beat is the final beat of a packet.
REQ-008 out_valid  output  1  packet result valid.
REQ-009 out_ready  input  1  downstream accepts the result.
REQ-010 out_data  output  12  packet sum.
REQ-011 out_ovf  output  OVF_W  count of adder carry-outs within the packet, saturating.

Function
REQ-012 A beat SHALL be accepted on a rising clk edge where in_valid and in_ready are both 1.
REQ-013 State machine states SHALL be IDLE (acc=0, no beats taken), ACCUM (at least one beat taken, no last yet) and HOLD (result presented).
REQ-014 in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD; it SHALL NOT depend combinationally on out_ready.
REQ-015 Each accepted beat SHALL compute acc + in_data with carry-in 0 through the 12-bit Ladner-Fischer adder, giving sum[11:0] and cout.
REQ-016 Accepted beat with in_last=0: acc <= sum, ovf_cnt <= ovf_cnt + cout (saturating at 2^OVF_W-1), next state ACCUM.
REQ-017 Accepted beat with in_last=1: out_data <= sum, out_ovf <= updated ovf_cnt, out_valid <= 1, acc <= 0, ovf_cnt <= 0, next state HOLD.
REQ-018 Latency SHALL be one cycle from the accepting edge of the last beat to out_valid=1.
REQ-019 A single-beat packet (in_last=1 in IDLE) SHALL go IDLE -> HOLD with out_data = in_data.
REQ-020 In HOLD, out_valid, out_data and out_ovf SHALL stay stable until a cycle with out_ready=1; on that edge out_valid <= 0 and state <= IDLE.
REQ-021 No beat SHALL be accepted on the edge that retires a result; the earliest next acceptance is the following cycle.
REQ-022 Default wrap-around: sum SHALL be taken modulo 4096; a carry affects only ovf_cnt.
REQ-023 in_data and in_last SHALL be ignored when in_valid=0.

Reset
REQ-024 While rst=1, independent of clk: state=IDLE, acc=0, ovf_cnt=0, out_valid=0, out_data=0, out_ovf=0, in_ready=1 after release.
REQ-025 rst asserted mid-packet or in HOLD SHALL discard partial sums and pending results with no output.

Configuration
REQ-026 Macro PP_ACCUM_SATURATE_EN: when defined, a beat with cout=1 SHALL set acc (or out_data on the last beat) to 0xFFF, and acc SHALL stay 0xFFF for the rest of the packet; ovf_cnt still counts every cout.
REQ-027 When PP_ACCUM_SATURATE_EN is not defined, behaviour SHALL be pure wrap per REQ-022 and the saturation logic SHALL NOT be present.

Structure
REQ-028 Shared package pp_adder_pkg SHALL hold the data width constant (12), the state enum (IDLE, ACCUM, HOLD) and the all-ones saturation constant.
REQ-029 Exactly one sub-module SHALL be instantiated: the existing 12-bit Ladner-Fischer adder, with cin tied to 0. All sequential logic stays in pp_accum_stage.

Verification
REQ-030 Beats 0x100, 0x200, 0x300 (last) with out_ready=1 -> out_data=0x600 and out_ovf=0 one cycle after the third beat is accepted; out_valid is high for one cycle.
REQ-031 Beats 0xFFF, 0x002 (last) -> wrap build: out_data=0x001, out_ovf=1; PP_ACCUM_SATURATE_EN build: out_data=0xFFF, out_ovf=1.
REQ-032 Single beat 0xABC with in_last=1, and out_ready=0 for 5 cycles -> out_valid=1, out_data=0xABC stable and in_ready=0 throughout; retired on the first out_ready=1 edge; in_ready=1 the next cycle.
REQ-033 Twenty beats of 0xFFF with OVF_W=4 -> out_ovf saturates at 15, and the wrap-build out_data equals (20*0xFFF) mod 4096 = 0xFEC.
REQ-034 rst pulsed after two beats of 0x010 -> no out_valid; then packet 0x005 (last) -> out_data=0x005, out_ovf=0.
